// File: rtl/handshake_sender.sv
// Transmit end of an 8-bit valid/ready bus.
// A start pulse launches a transfer of NUM_BEATS beats with values
// START_VAL, START_VAL+INC, ... (wrapping).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           begin a transfer (honoured in IDLE and DONE)
//   random_stall      suppress presenting a new beat this cycle
//   ready_i           receiver backpressure
//   valid_o, data_o   beat handshake and payload
//   busy_o, done_o    state flags (SEND / DONE)
//   beat_cnt_o        accepted beats in the current transfer
//   checksum_o        sum of accepted beats, modulo 2^DATA_W
module handshake_sender #(
    parameter int unsigned          DATA_W    = 8,
    parameter int unsigned          NUM_BEATS = 16,
    parameter logic [DATA_W-1:0]    START_VAL = '0,
    parameter int unsigned          INC       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              random_stall,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [7:0]        beat_cnt_o,
    output logic [DATA_W-1:0] checksum_o
);

    localparam int unsigned       CNT_W  = 8;
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(NUM_BEATS - 1);
    localparam logic [DATA_W-1:0] INC_V  = DATA_W'(INC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [DATA_W-1:0]   next_q, next_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            next_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            next_q  <= next_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        next_d  = next_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = SEND;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    sum_d   = '0;
                    next_d  = START_VAL;
                end
            end
            SEND: begin
                if (!valid_q) begin
                    if (!random_stall) begin
                        valid_d = 1'b1;
                        data_d  = next_q;
                    end
                end else if (ready_i) begin
                    // Beat accepted this edge
                    cnt_d  = cnt_q + CNT_W'(1);
                    sum_d  = sum_q + data_q;
                    next_d = data_q + INC_V;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                    end else if (!random_stall) begin
                        data_d = data_q + INC_V;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                // valid_q && !ready_i: hold everything (stall ignored)
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Flags track the state being entered so they line up with it
        busy_d = (state_d == SEND);
        done_d = (state_d == DONE);
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign beat_cnt_o = cnt_q;
    assign checksum_o = sum_q;

endmodule
